ntt_in_ctrl: RTL and testbench

NTT_IN_CTRL -- requirements
Module: ntt_in_ctrl

---
 rtl/ntt_in_ctrl_if.sv | 34 +++
 rtl/ntt_in_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ntt_in_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_in_ctrl_if.sv
// rtl/ntt_in_ctrl_if.sv - request/read-address bus of the NTT input address controller
interface ntt_in_ctrl_if #(
    parameter int LOG_N  = 8,
    parameter int ADDR_W = LOG_N - 2,
    parameter int STG_W  = $clog2(LOG_N)
);
    logic              start;
    logic              inv;
    logic              hold;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [ADDR_W-1:0] rd_addr3;
    logic [1:0]        sel_a_0;
    logic [1:0]        sel_a_1;
    logic [1:0]        sel_a_2;
    logic [1:0]        sel_a_3;
    logic [STG_W-1:0]  stage;
    logic              busy;
    logic              done;

    modport master (
        output start, inv, hold,
        input  rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
        input  sel_a_0, sel_a_1, sel_a_2, sel_a_3, stage, busy, done
    );

    modport slave (
        input  start, inv, hold,
        output rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
        output sel_a_0, sel_a_1, sel_a_2, sel_a_3, stage, busy, done
    );
endinterface

// File: rtl/ntt_in_ctrl.sv
// rtl/ntt_in_ctrl.sv - NTT stage sequencer issuing conflict-free 4-bank butterfly reads; NTT_IN_CTRL_INTT_EN enables inverse stage order
module ntt_in_ctrl #(
    parameter int LOG_N  = 8,
    parameter int ADDR_W = LOG_N - 2,
    parameter int GAP    = 4
) (
    input  logic          clk,
    input  logic          rst,
    ntt_in_ctrl_if.slave  bus
);
    localparam int CW    = LOG_N - 2;
    localparam int STG_W = $clog2(LOG_N);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0]    C_LAST   = '1;
    localparam logic [STG_W-1:0] S_LAST   = STG_W'(LOG_N - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [LOG_N-1:0] EVEN_M   = LOG_N'({LOG_N{2'b01}});
    localparam logic [LOG_N-1:0] ODD_M    = ~EVEN_M;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     c_q, c_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              inv_q, inv_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q [4];
    logic [ADDR_W-1:0] addr_d [4];
    logic [1:0]        sel_q  [4];
    logic [1:0]        sel_d  [4];

    logic              start_inv;
    logic              last_stage;
    logic [STG_W-1:0]  next_stage;

`ifdef NTT_IN_CTRL_INTT_EN
    assign start_inv = bus.inv;
`else
    logic unused_inv;
    assign start_inv  = 1'b0;
    assign unused_inv = bus.inv;
`endif

    assign last_stage = inv_q ? (stage_q == '0) : (stage_q == S_LAST);
    assign next_stage = inv_q ? (stage_q - 1'b1) : (stage_q + 1'b1);

    // rd_en_q marks that read c_q is on the outputs this cycle
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        stage_d = stage_q;
        gap_d   = gap_q;
        inv_d   = inv_q;
        rd_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    inv_d   = start_inv;
                    stage_d = start_inv ? S_LAST : '0;
                    c_d     = '0;
                    rd_en_d = 1'b1;
                end
            end
            RUN: begin
                if (rd_en_q && c_q == C_LAST) begin
                    state_d = WAIT;
                    gap_d   = '0;
                    c_d     = '0;
                end else begin
                    if (rd_en_q) c_d = c_q + 1'b1;
                    rd_en_d = !bus.hold;
                end
            end
            WAIT: begin
                if (gap_q == GAP_LAST) begin
                    if (last_stage) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = next_stage;
                        c_d     = '0;
                        rd_en_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [LOG_N-1:0]  h, g, cx, low_mask, a;
    logic [STG_W-1:0]  lo;
    logic [LOG_N-1:0]  idx    [4];
    logic [ADDR_W-1:0] addr_n [4];
    logic [1:0]        sel_n  [4];
    logic [1:0]        bank;

    // The two inserted zero bits (log2 h, log2 g) are always adjacent
    always_comb begin
        h        = LOG_N'(1) << stage_d;
        g        = (stage_d == S_LAST) ? (h >> 1) : (h << 1);
        lo       = (stage_d == S_LAST) ? (stage_d - 1'b1) : stage_d;
        cx       = LOG_N'(c_d);
        low_mask = (LOG_N'(1) << lo) - LOG_N'(1);
        a        = ((cx & ~low_mask) << 2) | (cx & low_mask);
        idx[0]   = a;
        idx[1]   = a | h;
        idx[2]   = a | g;
        idx[3]   = a | g | h;
        addr_n   = '{default: '0};
        sel_n    = '{default: '0};
        bank     = '0;
        for (int k = 0; k < 4; k++) begin
            bank         = {^(idx[k] & ODD_M), ^(idx[k] & EVEN_M)};
            addr_n[bank] = ADDR_W'(idx[k] >> 2);
            sel_n[bank]  = 2'(k);
        end
        for (int k = 0; k < 4; k++) begin
            addr_d[k] = rd_en_d ? addr_n[k] : '0;
            sel_d[k]  = rd_en_d ? sel_n[k]  : 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            stage_q <= '0;
            gap_q   <= '0;
            inv_q   <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '{default: '0};
            sel_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            stage_q <= stage_d;
            gap_q   <= gap_d;
            inv_q   <= inv_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr0 = addr_q[0];
    assign bus.rd_addr1 = addr_q[1];
    assign bus.rd_addr2 = addr_q[2];
    assign bus.rd_addr3 = addr_q[3];
    assign bus.sel_a_0  = sel_q[0];
    assign bus.sel_a_1  = sel_q[1];
    assign bus.sel_a_2  = sel_q[2];
    assign bus.sel_a_3  = sel_q[3];
    assign bus.stage    = stage_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_ntt_in_ctrl.sv
// tb/tb_ntt_in_ctrl.sv - scoreboard bench for ntt_in_ctrl
module tb_ntt_in_ctrl;
    localparam int LOG_N   = 8;
    localparam int ADDR_W  = LOG_N - 2;
    localparam int GAP     = 4;
    localparam int N       = 1 << LOG_N;
    localparam int Q       = N / 4;
    localparam int RUN_LEN = LOG_N * (Q + GAP);
`ifdef NTT_IN_CTRL_INTT_EN
    localparam bit INTT = 1'b1;
`else
    localparam bit INTT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   rd_cnt = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_in_ctrl_if #(.LOG_N(LOG_N), .ADDR_W(ADDR_W)) bus ();

    ntt_in_ctrl #(.LOG_N(LOG_N), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_read(input int s, input int c);
        int h, g, a, ci, bk;
        int idx [4];
        int addr [4];
        int sel [4];
        logic [63:0] low;
        h  = 1 << s;
        g  = (s < LOG_N - 1) ? (1 << (s + 1)) : (1 << (s - 1));
        a  = 0;
        ci = 0;
        for (int b = 0; b < LOG_N; b++) begin
            if ((1 << b) != h && (1 << b) != g) begin
                a  = a | (((c >> ci) & 1) << b);
                ci++;
            end
        end
        idx[0] = a; idx[1] = a + h; idx[2] = a + g; idx[3] = a + g + h;
        for (int k = 0; k < 4; k++) begin
            bk = 0;
            for (int b = 0; b < LOG_N; b++)
                if (((idx[k] >> b) & 1) == 1) bk = bk ^ (((b % 2) == 1) ? 2 : 1);
            addr[bk] = idx[k] >> 2;
            sel[bk]  = k;
        end
        low = 0;
        for (int k = 0; k < 4; k++) low = (low << ADDR_W) | 64'(addr[k]);
        for (int k = 0; k < 4; k++) low = (low << 2) | 64'(sel[k]);
        return (64'(s) << 32) | low;
    endfunction

    function automatic logic [63:0] addr_pack();
        return 64'({bus.rd_addr0, bus.rd_addr1, bus.rd_addr2, bus.rd_addr3});
    endfunction

    function automatic logic [63:0] sel_pack();
        return 64'({bus.sel_a_0, bus.sel_a_1, bus.sel_a_2, bus.sel_a_3});
    endfunction

    task automatic push_transform(input bit inv_b);
        int s;
        for (int i = 0; i < LOG_N; i++) begin
            s = inv_b ? (LOG_N - 1 - i) : i;
            for (int c = 0; c < Q; c++) exp_q.push_back(exp_read(s, c));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                rd_cnt++;
                if (exp_q.size() == 0)
                    check_val("sb_underflow", 64'd1, 64'd0);
                else
                    check_val("sb_read", (64'(bus.stage) << 32) | (addr_pack() << 8) | sel_pack(),
                              exp_q.pop_front());
            end else begin
                check_val("idle_zero", (addr_pack() << 8) | sel_pack(), 64'd0);
            end
        end
    end

    task automatic do_start(input bit inv_b, output int t0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.inv   = inv_b;
        rd_cnt    = 0;
        push_transform(inv_b && INTT);
        @(negedge clk);
        bus.start = 1'b0;
        bus.inv   = 1'b0;
        t0        = cyc;
    endtask

    task automatic wait_read(input int s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.rd_en && int'(bus.stage) == s) ok = 1'b1;
        end
        if (!ok) check_val($sformatf("timeout_stage%0d", s), 64'd0, 64'd1);
    endtask

    task automatic wait_done(output int dc);
        bit ok;
        ok = 1'b0;
        dc = -1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                dc = cyc;
            end
        end
        if (!ok) check_val("timeout_done", 64'd0, 64'd1);
    endtask

    initial begin
        int  t0, dc;
        bit  ok;
        bus.start = 1'b0;
        bus.inv   = 1'b0;
        bus.hold  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_rd_en", 64'(bus.rd_en), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_stage", 64'(bus.stage), 64'd0);
        check_val("rst_outs", (addr_pack() << 8) | sel_pack(), 64'd0);
        rst = 1'b0;

        // plain forward run with ignored starts while busy
        do_start(1'b0, t0);
        check_val("first_rd_en", 64'(bus.rd_en), 64'd1);
        check_val("first_busy", 64'(bus.busy), 64'd1);
        check_val("s0c0_addr", addr_pack(), 64'h0);
        check_val("s0c0_sel", sel_pack(), 64'b00_01_10_11);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("s0c1_addr", addr_pack(), 64'({6'd1, 6'd1, 6'd1, 6'd1}));
        check_val("s0c1_sel", sel_pack(), 64'b01_00_11_10);
        wait_read(LOG_N - 1, ok);
        if (ok) begin
            check_val("s7c0_addr", addr_pack(), 64'({6'd0, 6'd16, 6'd32, 6'd48}));
            check_val("s7c0_sel", sel_pack(), 64'b00_10_01_11);
            check_val("s7_start_cyc", 64'(cyc - t0), 64'((LOG_N - 1) * (Q + GAP)));
        end
        wait_done(dc);
        check_val("done_latency", 64'(dc - t0), 64'(RUN_LEN));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("after_done_busy", 64'(bus.busy), 64'd0);
        check_val("after_done_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        check_val("start_in_done_ignored", 64'(bus.busy), 64'd0);
        check_val("rd_count", 64'(rd_cnt), 64'(N * LOG_N / 4));
        check_val("sb_empty_1", 64'(exp_q.size()), 64'd0);

        // hold for three cycles inside stage 2
        do_start(1'b0, t0);
        wait_read(2, ok);
        repeat (4) @(negedge clk);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val($sformatf("hold_rd_en_%0d", i), 64'(bus.rd_en), 64'd0);
        end
        bus.hold = 1'b0;
        @(negedge clk);
        check_val("hold_resume", 64'(bus.rd_en), 64'd1);
        wait_done(dc);
        check_val("hold_done_latency", 64'(dc - t0), 64'(RUN_LEN + 3));
        check_val("hold_rd_count", 64'(rd_cnt), 64'(N * LOG_N / 4));
        check_val("sb_empty_2", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);

        // asynchronous reset mid stage 3, then inverse-request run
        do_start(1'b0, t0);
        wait_read(3, ok);
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("arst_rd_en", 64'(bus.rd_en), 64'd0);
        check_val("arst_busy", 64'(bus.busy), 64'd0);
        check_val("arst_stage", 64'(bus.stage), 64'd0);
        check_val("arst_outs", (addr_pack() << 8) | sel_pack(), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("no_resume", 64'(bus.busy), 64'd0);
        do_start(1'b1, t0);
        check_val("inv_first_stage", 64'(bus.stage), INTT ? 64'(LOG_N - 1) : 64'd0);
        check_val("inv_first_rd_en", 64'(bus.rd_en), 64'd1);
        wait_done(dc);
        check_val("inv_done_latency", 64'(dc - t0), 64'(RUN_LEN));
        check_val("sb_empty_3", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
